// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
// ----------------
// SPI master that sends 10-bit frames {cmd[1:0], payload[7:0]} MSB first to
// the SPI slave / single-port-RAM subsystem. For cmd 11 (read data) it waits
// TURNAROUND idle cycles after the last MOSI bit, then shifts in 8 MISO bits
// and returns them to the host. The SPI bit clock is clk itself.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   req_valid  host request valid
//   req_ready  high only while IDLE (registered, low during reset)
//   req_cmd    00 wr addr, 01 wr data, 10 rd addr, 11 rd data
//   req_data   payload (shifted out even for cmd 11)
//   rsp_valid  one-cycle pulse in END of a cmd 11 frame
//   rsp_data   read byte, held until the next rsp_valid
//   busy       high from accept until back in IDLE
//   SS_n       slave select, active low
//   MOSI       serial data to slave, MSB first
//   MISO       serial data from slave, MSB first
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_cmd/req_data are captured on that edge and ignored afterwards; there is
// no backpressure on the response side (rsp_valid is a single-cycle pulse).
//
// Frame timeline (A = accept edge cycle):
//   A+1 START (SS_n low, MOSI = cmd[1]), A+2..A+11 SHIFT (10 bits),
//   [read data only: TURNAROUND cycles TURN, 8 cycles RECV], then END, IDLE.
// Every output is a flop whose D input is decoded from the next state, so
// nothing reaches the pins combinationally from MISO or req_*.

module spi_master_ctrl #(
  parameter int TURNAROUND = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_cmd,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT,
    S_TURN,
    S_RECV,
    S_END
  } state_e;

  localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);

  state_e      state_q, state_d;
  logic [9:0]  tx_q, tx_d;
  // Only 7 bits are stored: the 8th received bit goes straight into rsp_data.
  logic [6:0]  rx_q, rx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rd_q, rd_d;
  logic        ss_n_q, ss_n_d;
  logic        mosi_q, mosi_d;
  logic        req_ready_q, req_ready_d;
  logic        busy_q, busy_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          tx_d    = {req_cmd, req_data};
          rd_d    = (req_cmd == 2'b11);
          cnt_d   = 4'd0;
          rx_d    = 7'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        // Slave command-check cycle; tx is held so bit 9 repeats in SHIFT 0.
        cnt_d   = 4'd0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        tx_d = {tx_q[8:0], 1'b0};
        if (cnt_q == 4'd9) begin
          cnt_d   = 4'd0;
          state_d = rd_q ? S_TURN : S_END;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_TURN: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_RECV;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RECV: begin
        rx_d = {rx_q[5:0], MISO};
        if (cnt_q == 4'd7) begin
          cnt_d       = 4'd0;
          state_d     = S_END;
          rsp_valid_d = 1'b1;
          rsp_data_d  = {rx_q, MISO};
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pin values are decoded from the state being entered so they are
    // registered alongside it.
    ss_n_d      = (state_d == S_IDLE) || (state_d == S_END);
    mosi_d      = ((state_d == S_START) || (state_d == S_SHIFT)) ? tx_d[9] : 1'b0;
    busy_d      = (state_d != S_IDLE);
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tx_q        <= 10'd0;
      rx_q        <= 7'd0;
      cnt_q       <= 4'd0;
      rd_q        <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Single-clock SPI master that issues 10-bit command frames (2-bit command + 8-bit payload) to the SPI slave/single-port-RAM subsystem and returns read data to a host. It sits between a parallel host request interface and the serial `SS_n`/`MOSI`/`MISO` pins of the slave. The SPI bit clock is the system clock `clk`, which the slave shares. The block is intended as both a production master and the stimulus engine for system-level RAM-over-SPI testing.

## Interface
- `TURNAROUND`, default 2: idle cycles between the last MOSI bit of a read-data frame and the first sampled MISO bit (legal 1–7).
- `clk`  input  1  system clock; all logic on rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `req_valid`  input  1  host request valid.
- `req_ready`  output  1  block can accept a request (high only in IDLE).
- `req_cmd`  input  2  00 write address, 01 write data, 10 read address, 11 read data.
- `req_data`  input  8  payload; don't-care content for 11 but still shifted.
- `rsp_valid`  output  1  one-cycle pulse, read data available (cmd 11 only).
- `rsp_data`  output  8  read byte, held until next rsp_valid.
- `busy`  output  1  high from accept until return to IDLE.
- `SS_n`  output  1  slave select, active low.
- `MOSI`  output  1  serial data to slave, MSB first.
- `MISO`  input  1  serial data from slave, MSB first.

## Operation
- Handshake: accept when `req_valid && req_ready`; `req_cmd`/`req_data` are captured into a 10-bit shift register `{cmd, data}` on that edge. Host inputs are ignored after capture.
- FSM states: IDLE, START, SHIFT, TURN, RECV, END.
- IDLE: `SS_n`=1, `MOSI`=0, `req_ready`=1. On accept, go to START.
- START (1 cycle): `SS_n`=0, `MOSI`=cmd[1]. This is the slave's command-check cycle. Go to SHIFT.
- SHIFT (10 cycles): `SS_n`=0, `MOSI`=shift[9], then shift left. A 4-bit counter runs 0–9. After count 9: cmd 11 goes to TURN; all other commands go to END.
- TURN (`TURNAROUND` cycles): `SS_n`=0, `MOSI`=0, and MISO is ignored. Then go to RECV.
- RECV (8 cycles): `SS_n`=0, `MOSI`=0. `MISO` is sampled every cycle into an 8-bit shift register, MSB first. Then go to END.
- END (1 cycle): `SS_n`=1, `MOSI`=0. For cmd 11, `rsp_data` is loaded and `rsp_valid`=1 this cycle. Then go to IDLE.
- `busy` = (state != IDLE). `req_ready` = (state == IDLE) and not in reset.
- Command sequencing (address before data) is the host's responsibility. The block does not check it.
- Reset asserted in any state: on the next edge go to IDLE. Outputs become `SS_n`=1, `MOSI`=0, `rsp_valid`=0, `rsp_data`=0, `busy`=0, and shift registers and counters clear. An aborted frame produces no `rsp_valid`.

## Timing
- Reset values: `SS_n`=1, `MOSI`=0, `req_ready`=0 while `rst_n`=0 (1 after release), `rsp_valid`=0, `rsp_data`=8'h00, `busy`=0.
- The accept edge is cycle A. `SS_n` falls in cycle A+1 (START). The first MOSI bit (cmd[1]) is driven in cycle A+2.
- Write and read-address frames: `SS_n` is low for 11 cycles (A+1..A+11). END is at A+12. IDLE and `req_ready`=1 return at A+13.
- Read-data frame: `SS_n` is low for 11+`TURNAROUND`+8 cycles. With default 2 that is 21 cycles (A+1..A+21). `rsp_valid` is asserted at A+22, and IDLE returns at A+23.
- Back-to-back: the minimum gap between frames is `SS_n` high for 2 cycles (END + IDLE accept cycle).
- All outputs are registered, with no combinational path from `MISO` or `req_*` to outputs.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `req_valid`=1 -> `SS_n`=1, `MOSI`=0, `req_ready`=0, no frame. `req_ready`=1 the cycle after release.
- Write address: req {00, 8'h3A} -> `SS_n` low exactly 11 cycles; MOSI sequence 0, then 0,0,0,0,1,1,1,0,1,0; no `rsp_valid`.
- RAM loopback against the SPI slave + RAM top: write address 8'h3A, write data 8'hC5, read address 8'h3A, read data -> `rsp_valid` pulse at A+22 with `rsp_data`=8'hC5.
- Back-to-back: `req_valid` held high with 4 queued requests -> each `SS_n` high gap is exactly 2 cycles; `req_ready` is high only in IDLE cycles.
- Reset mid-frame: assert `rst_n`=0 during RECV bit 4 of a read -> `SS_n`=1 next edge, no `rsp_valid`, and `rsp_data`=0. A following read of 8'hC5 completes correctly.
- TURNAROUND=1 and 7 builds: MISO fed from a bench model -> `SS_n` low 20 and 26 cycles respectively, and the correct byte is captured.
